// File: rtl/rc4_nibble_engine.sv
`default_nettype none
// ============================================================================
// Module   : rc4_nibble_engine
// Brief    : 4-bit RC4 variant (16-entry S-box): INIT, key schedule and
//            keystream generation with valid/ready output and swap mirror.
// Revision : 1.0
// ============================================================================
module rc4_nibble_engine #(
    parameter int KEY_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [4*KEY_LEN-1:0]   key,
    output logic                   busy,
    output logic                   ks_valid,
    input  logic                   ks_ready,
    output logic [3:0]             ks_data,
    output logic                   mir_we,
    output logic [3:0]             mir_addr1,
    output logic [3:0]             mir_addr2,
    output logic [3:0]             mir_data1,
    output logic [3:0]             mir_data2
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_KSA  = 2'd2,
        ST_PRGA = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_s [16];
    logic [3:0]           r_i;
    logic [3:0]           r_j;
    logic [4*KEY_LEN-1:0] r_key;
    logic [3:0]           r_ks_data;
    logic                 r_ks_valid;

    logic [4:0] w_kidx;
    logic [3:0] w_knib;
    logic [3:0] w_si;
    logic [3:0] w_jn;
    logic [3:0] w_s_jn;
    logic [3:0] w_ip;
    logic [3:0] w_sip;
    logic [3:0] w_jp;
    logic [3:0] w_sjp;
    logic [3:0] w_t;
    logic [3:0] w_out;
    logic       w_step;
    logic       w_we;
    logic [3:0] w_a1;
    logic [3:0] w_a2;
    logic [3:0] w_d1;
    logic [3:0] w_d2;

    // Key schedule datapath
    assign w_kidx = {1'b0, r_i} % 5'(KEY_LEN);
    assign w_knib = r_key[{w_kidx, 2'b00} +: 4];
    assign w_si   = r_s[r_i];
    assign w_jn   = r_j + w_si + w_knib;
    assign w_s_jn = r_s[w_jn];

    // Generate datapath; output index is looked up in the post-swap array
    assign w_ip  = r_i + 4'd1;
    assign w_sip = r_s[w_ip];
    assign w_jp  = r_j + w_sip;
    assign w_sjp = r_s[w_jp];
    assign w_t   = w_sip + w_sjp;
    assign w_out = (w_t == w_ip) ? w_sjp :
                   (w_t == w_jp) ? w_sip : r_s[w_t];

    assign w_step = (r_state == ST_PRGA) && (!r_ks_valid || ks_ready);

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_a1        = 4'd0;
        w_a2        = 4'd0;
        w_d1        = 4'd0;
        w_d2        = 4'd0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                w_we = 1'b1;
                w_a1 = r_i;
                w_a2 = r_i;
                w_d1 = r_i;
                w_d2 = r_i;
                if (r_i == 4'd15) begin
                    w_state_nxt = ST_KSA;
                end
            end
            ST_KSA: begin
                w_we = 1'b1;
                w_a1 = r_i;
                w_d1 = w_s_jn;
                w_a2 = w_jn;
                w_d2 = w_si;
                if (r_i == 4'd15) begin
                    w_state_nxt = ST_PRGA;
                end
            end
            ST_PRGA: begin
                if (w_step) begin
                    w_we = 1'b1;
                    w_a1 = w_ip;
                    w_d1 = w_sjp;
                    w_a2 = w_jp;
                    w_d2 = w_sip;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (stop) begin
            w_state_nxt = ST_IDLE;
            w_we        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_i        <= 4'd0;
            r_j        <= 4'd0;
            r_key      <= '0;
            r_ks_data  <= 4'd0;
            r_ks_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (stop) begin
                r_ks_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_key <= key;
                            r_i   <= 4'd0;
                            r_j   <= 4'd0;
                        end
                    end
                    ST_INIT: begin
                        r_i <= r_i + 4'd1;
                        r_j <= 4'd0;
                    end
                    ST_KSA: begin
                        r_i <= r_i + 4'd1;
                        r_j <= (r_i == 4'd15) ? 4'd0 : w_jn;
                    end
                    ST_PRGA: begin
                        if (w_step) begin
                            r_i        <= w_ip;
                            r_j        <= w_jp;
                            r_ks_data  <= w_out;
                            r_ks_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // The S-box is updated through the same write port the mirror sees
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_s[w_a1] <= w_d1;
            r_s[w_a2] <= w_d2;
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign ks_valid  = r_ks_valid;
    assign ks_data   = r_ks_data;
    assign mir_we    = w_we;
    assign mir_addr1 = w_a1;
    assign mir_addr2 = w_a2;
    assign mir_data1 = w_d1;
    assign mir_data2 = w_d2;

endmodule
`default_nettype wire
